// File: rtl/alu_cmd_loader.sv
// alu_cmd_loader: bit-serial command assembler feeding the two-operand ALU.
// One output slot plus one hold slot decouple serial loading from consumer stalls.
module alu_cmd_loader #(
  parameter  int WIDTH = 6,
  parameter  int SEL_W = 2,
  localparam int FRAME = 2*WIDTH + SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [SEL_W-1:0] Select,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       frame_cnt
);

  localparam int CNT_W = $clog2(FRAME);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [FRAME-1:0] hold_q, hold_d;
  logic [FRAME-1:0] out_q, out_d;
  logic [7:0]       fcnt_q, fcnt_d;

  logic             accept;
  logic             last;
  logic             drain;
  logic [FRAME-1:0] frame_w;

  assign ser_ready = (state_q != S_FULL);
  assign cmd_valid = (state_q != S_EMPTY);
  assign A         = out_q[WIDTH-1:0];
  assign B         = out_q[2*WIDTH-1:WIDTH];
  assign Select    = out_q[FRAME-1:2*WIDTH];
  assign frame_cnt = fcnt_q;

  // abort wins over a coincident bit, so the bit never reaches the frame
  assign accept  = ser_valid && ser_ready && !abort;
  assign last    = accept && (bit_cnt_q == CNT_W'(FRAME-1));
  assign drain   = cmd_valid && cmd_ready;
  assign frame_w = {ser_in, shift_q[FRAME-1:1]};

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (abort) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (accept) begin
      shift_d   = frame_w;
      bit_cnt_d = last ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hold_d  = hold_q;
    fcnt_d  = drain ? fcnt_q + 8'd1 : fcnt_q;
    unique case (1'b1)
      (state_q == S_EMPTY): begin
        if (last) begin
          out_d   = frame_w;
          state_d = S_ONE;
        end
      end
      (state_q == S_ONE): begin
        if (last && !drain) begin
          hold_d  = frame_w;
          state_d = S_FULL;
        end else if (last && drain) begin
          out_d   = frame_w;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      (state_q == S_FULL): begin
        if (drain) begin
          out_d   = hold_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      hold_q    <= '0;
      out_q     <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      fcnt_q    <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_loader.sv
// tb_alu_cmd_loader: directed checks of the serial command loader.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_cmd_loader;

  logic       clk;
  logic       rst_n;
  logic       ser_in;
  logic       ser_valid;
  logic       ser_ready;
  logic       abort;
  logic [5:0] A;
  logic [5:0] B;
  logic [1:0] Select;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  alu_cmd_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .abort     (abort),
    .A         (A),
    .B         (B),
    .Select    (Select),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic [5:0] a,
                                     input logic [5:0] b,
                                     input logic [1:0] s);
    return {s, b, a};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [13:0] f, input int lo, input int hi);
    logic [13:0] v;
    v = f;
    for (int k = lo; k <= hi; k++) begin
      ser_in    = v[k];
      ser_valid = 1'b1;
      tick();
    end
  endtask

  task automatic send_frame(input logic [13:0] f);
    send_bits(f, 0, 13);
    ser_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    ser_in    = 1'b0;
    ser_valid = 1'b0;
    abort     = 1'b0;
    cmd_ready = 1'b0;
    #1;
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_sel", Select, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_fcnt", frame_cnt, 0);
    do_reset();
    check("rst_ser_ready", ser_ready, 1);

    // 1: plain frame, consumer always ready
    cmd_ready = 1'b1;
    send_bits(14'h060F, 0, 12);
    check("t1_not_yet", cmd_valid, 0);
    send_bits(14'h060F, 13, 13);
    ser_valid = 1'b0;
    check("t1_valid", cmd_valid, 1);
    check("t1_A", A, 15);
    check("t1_B", B, 24);
    check("t1_sel", Select, 0);
    check("t1_fcnt_pre", frame_cnt, 0);
    tick();
    check("t1_valid_drop", cmd_valid, 0);
    check("t1_fcnt", frame_cnt, 1);
    check("t1_A_keep", A, 15);

    // 2: frame with three idle cycles in the middle
    send_bits(14'h2D52, 0, 6);
    ser_valid = 1'b0;
    tick();
    tick();
    tick();
    send_bits(14'h2D52, 7, 12);
    check("t2_not_yet", cmd_valid, 0);
    send_bits(14'h2D52, 13, 13);
    ser_valid = 1'b0;
    check("t2_valid", cmd_valid, 1);
    check("t2_A", A, 18);
    check("t2_B", B, 53);
    check("t2_sel", Select, 2);
    tick();
    check("t2_fcnt", frame_cnt, 2);

    // 3: backpressure fills the hold slot
    cmd_ready = 1'b0;
    send_frame(mk(6'd3, 6'd5, 2'd1));
    check("t3_valid1", cmd_valid, 1);
    check("t3_rdy1", ser_ready, 1);
    send_frame(mk(6'd15, 6'd8, 2'd1));
    check("t3_full_rdy", ser_ready, 0);
    check("t3_A_hold", A, 3);
    check("t3_B_hold", B, 5);
    check("t3_sel_hold", Select, 1);
    ser_in    = 1'b1;
    ser_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ser_valid = 1'b0;
    check("t3_stall_rdy", ser_ready, 0);
    check("t3_stall_A", A, 3);
    check("t3_fcnt_stall", frame_cnt, 2);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("t3_A_new", A, 15);
    check("t3_B_new", B, 8);
    check("t3_sel_new", Select, 1);
    check("t3_rdy_back", ser_ready, 1);
    check("t3_valid_new", cmd_valid, 1);
    check("t3_fcnt", frame_cnt, 3);
    cmd_ready = 1'b1;
    tick();
    check("t3_empty", cmd_valid, 0);
    check("t3_fcnt2", frame_cnt, 4);

    // 4: abort discards a partial frame and a coincident bit
    send_bits(14'h3FFF, 0, 6);
    ser_in    = 1'b1;
    ser_valid = 1'b1;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    ser_valid = 1'b0;
    check("t4_abort_A", A, 15);
    check("t4_abort_valid", cmd_valid, 0);
    send_frame(mk(6'd7, 6'd2, 2'd3));
    check("t4_valid", cmd_valid, 1);
    check("t4_A", A, 7);
    check("t4_B", B, 2);
    check("t4_sel", Select, 3);
    tick();
    check("t4_fcnt", frame_cnt, 5);

    // 5: asynchronous reset in the middle of a frame
    cmd_ready = 1'b0;
    send_bits(14'h3FFF, 0, 9);
    ser_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_A", A, 0);
    check("t5_B", B, 0);
    check("t5_sel", Select, 0);
    check("t5_valid", cmd_valid, 0);
    check("t5_fcnt", frame_cnt, 0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("t5_rdy", ser_ready, 1);
    cmd_ready = 1'b1;
    send_frame(mk(6'd4, 6'd2, 2'd0));
    check("t5_A2", A, 4);
    check("t5_B2", B, 2);
    check("t5_sel2", Select, 0);
    check("t5_valid2", cmd_valid, 1);
    tick();
    check("t5_fcnt2", frame_cnt, 1);

    // 6: frame counter wrap
    do_reset();
    cmd_ready = 1'b1;
    for (int i = 0; i < 255; i++) send_frame(mk(6'(i), 6'(i + 1), 2'(i)));
    tick();
    check("t6_fcnt255", frame_cnt, 255);
    send_frame(mk(6'd33, 6'd44, 2'd2));
    check("t6_A", A, 33);
    check("t6_B", B, 44);
    tick();
    check("t6_wrap", frame_cnt, 0);

    // 7: new frame completes in the same cycle the old one drains
    cmd_ready = 1'b0;
    send_frame(mk(6'd9, 6'd10, 2'd1));
    check("t7_A_first", A, 9);
    send_bits(mk(6'd20, 6'd30, 2'd2), 0, 12);
    cmd_ready = 1'b1;
    send_bits(mk(6'd20, 6'd30, 2'd2), 13, 13);
    ser_valid = 1'b0;
    cmd_ready = 1'b0;
    check("t7_valid", cmd_valid, 1);
    check("t7_A", A, 20);
    check("t7_B", B, 30);
    check("t7_sel", Select, 2);
    check("t7_rdy", ser_ready, 1);
    check("t7_fcnt", frame_cnt, 1);
    tick();
    check("t7_still_valid", cmd_valid, 1);
    check("t7_A_stable", A, 20);
    cmd_ready = 1'b1;
    tick();
    check("t7_empty", cmd_valid, 0);
    check("t7_fcnt2", frame_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
